// File: rtl/breakout_pkg.sv
// Game-state encoding for the Breakout flow controller.
// The top level and the pong_graph glue also use this encoding.
package breakout_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } game_state_t;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD score counter that saturates at 9999. clr has priority over inc.
// Latency: q updates on the edge that samples clr/inc. There is no backpressure.
module bcd_counter4 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] q
);

    logic [15:0] nxt;
    logic        carry;

    // Ripple a carry up through the digits. Each digit wraps 9 -> 0 when a carry arrives.
    always_comb begin
        nxt   = q;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (q[4*i +: 4] == 4'd9) begin
                    nxt[4*i +: 4] = 4'd0;
                end else begin
                    nxt[4*i +: 4] = q[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= 16'h0000;
        end else if (clr) begin
            q <= 16'h0000;
        end else if (inc && (q != 16'h9999)) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/breakout_ctrl.sv
// Breakout game-flow FSM: edge-detected keypad/hit/miss events, ball counter, pause timer and BCD score.
// Latency: an input edge is registered for 1 cycle and takes effect on the following edge. There is no backpressure.
module breakout_ctrl
    import breakout_pkg::*;
#(
    parameter int          BALLS_INIT    = 3,
    parameter logic [4:0]  START_KEY     = 5'h10,
    parameter int          NEWBALL_TICKS = 50_000_000,
    parameter int          OVER_TICKS    = 200_000_000,
    parameter int          TIMER_W       = 28
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        key_ready,
    input  logic [4:0]  key_code,
    input  logic        hit,
    input  logic        miss,
    output logic [1:0]  state,
    output logic        gra_still,
    output logic [3:0]  balls_left,
    output logic [15:0] score_bcd,
    output logic [31:0] seg_data
);

    localparam logic [3:0]         BALLS_RST  = 4'(BALLS_INIT);
    localparam logic [TIMER_W-1:0] NB_LOAD    = TIMER_W'(NEWBALL_TICKS - 1);
    localparam logic [TIMER_W-1:0] OVER_LOAD  = TIMER_W'(OVER_TICKS - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    game_state_t        st;
    logic [TIMER_W-1:0] timer;
    logic               key_ready_d, hit_d, miss_d;
    logic               key_ev, hit_ev, miss_ev;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st          <= NEWGAME;
            timer       <= '0;
            balls_left  <= BALLS_RST;
            key_ready_d <= 1'b0;
            hit_d       <= 1'b0;
            miss_d      <= 1'b0;
            key_ev      <= 1'b0;
            hit_ev      <= 1'b0;
            miss_ev     <= 1'b0;
        end else begin
            key_ready_d <= key_ready;
            hit_d       <= hit;
            miss_d      <= miss;
            key_ev      <= key_ready & ~key_ready_d & (key_code == START_KEY);
            hit_ev      <= hit & ~hit_d;
            miss_ev     <= miss & ~miss_d;

            case (st)
                NEWGAME: begin
                    if (key_ev) begin
                        st         <= PLAY;
                        balls_left <= BALLS_RST;
                    end
                end
                PLAY: begin
                    // The score increment for a same-cycle hit is handled by the counter alongside this transition.
                    if (miss_ev) begin
                        if (balls_left > 4'd1) begin
                            balls_left <= balls_left - 4'd1;
                            timer      <= NB_LOAD;
                            st         <= NEWBALL;
                        end else begin
                            balls_left <= 4'd0;
                            timer      <= OVER_LOAD;
                            st         <= OVER;
                        end
                    end
                end
                NEWBALL: begin
                    if (timer == '0) st <= PLAY;
                    else             timer <= timer - TIMER_ONE;
                end
                OVER: begin
                    if (timer == '0) begin
                        st         <= NEWGAME;
                        balls_left <= BALLS_RST;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                default: st <= NEWGAME;
            endcase
        end
    end

    bcd_counter4 u_score (
        .clk  (clk),
        .rstn (rstn),
        .clr  ((st == NEWGAME) && key_ev),
        .inc  ((st == PLAY) && hit_ev),
        .q    (score_bcd)
    );

    assign state     = st;
    assign gra_still = (st != PLAY);
    assign seg_data  = {score_bcd, 12'h000, balls_left};

endmodule

// File: tb/tb_breakout_ctrl.sv
// Bench for breakout_ctrl with short pause timers. It uses a vector table, hand sequences and a random run against a reference model.
module tb_breakout_ctrl;

    localparam int NB = 4;
    localparam int OT = 6;
    localparam int BI = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        key_ready = 1'b0;
    logic [4:0]  key_code = 5'h00;
    logic        hit = 1'b0;
    logic        miss = 1'b0;
    logic [1:0]  state;
    logic        gra_still;
    logic [3:0]  balls_left;
    logic [15:0] score_bcd;
    logic [31:0] seg_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    breakout_ctrl #(
        .BALLS_INIT    (BI),
        .START_KEY     (5'h10),
        .NEWBALL_TICKS (NB),
        .OVER_TICKS    (OT),
        .TIMER_W       (28)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .key_ready  (key_ready),
        .key_code   (key_code),
        .hit        (hit),
        .miss       (miss),
        .state      (state),
        .gra_still  (gra_still),
        .balls_left (balls_left),
        .score_bcd  (score_bcd),
        .seg_data   (seg_data)
    );

    typedef struct {
        logic       kr;
        logic [4:0] kc;
        logic       h;
        logic       m;
        int         st;
        int         b;
        int         s;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [15:0] tobcd(int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_all(string tag, int est, int eb, int es);
        chk({tag, ".state"}, 32'(state), 32'(est));
        chk({tag, ".gra_still"}, 32'(gra_still), 32'(est != 1));
        chk({tag, ".balls"}, 32'(balls_left), 32'(eb));
        chk({tag, ".score"}, 32'(score_bcd), 32'(tobcd(es)));
        chk({tag, ".seg"}, seg_data, {tobcd(es), 12'h000, 4'(eb)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; key_ready = 1'b0; hit = 1'b0; miss = 1'b0; key_code = 5'h00;
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic start_game();
        key_code = 5'h10; key_ready = 1'b1; tick();
        key_ready = 1'b0; tick();
    endtask

    task automatic pulse_hit();
        hit = 1'b1; tick();
        hit = 1'b0; tick();
    endtask

    task automatic pulse_miss();
        miss = 1'b1; tick();
        miss = 1'b0; tick();
    endtask

    // Reference model state, kept in plain game terms.
    int  m_st, m_b, m_s, m_wake, m_cyc;
    bit  m_pk, m_ph, m_pm, m_prev_kr, m_prev_h, m_prev_m;

    task automatic model_reset();
        m_st = 0; m_b = BI; m_s = 0; m_wake = 0;
        m_pk = 0; m_ph = 0; m_pm = 0; m_prev_kr = 0; m_prev_h = 0; m_prev_m = 0;
    endtask

    task automatic model_edge(bit r, bit kr, logic [4:0] kc, bit h, bit m);
        if (!r) begin
            model_reset();
        end else begin
            case (m_st)
                0: if (m_pk) begin m_st = 1; m_s = 0; m_b = BI; end
                1: begin
                    if (m_ph && m_s < 9999) m_s = m_s + 1;
                    if (m_pm) begin
                        if (m_b > 1) begin m_b = m_b - 1; m_st = 2; m_wake = m_cyc + NB; end
                        else begin m_b = 0; m_st = 3; m_wake = m_cyc + OT; end
                    end
                end
                2: if (m_cyc == m_wake) m_st = 1;
                default: if (m_cyc == m_wake) begin m_st = 0; m_b = BI; end
            endcase
            m_pk = kr && !m_prev_kr && (kc == 5'h10);
            m_ph = h && !m_prev_h;
            m_pm = m_prev_m ? 1'b0 : m;
            m_prev_kr = kr; m_prev_h = h; m_prev_m = m;
        end
        m_cyc++;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 5'h00, 1'b0, 1'b0, 0, 3, 0};
        tbl[1]  = '{1'b1, 5'h0c, 1'b0, 1'b0, 0, 3, 0};
        tbl[2]  = '{1'b0, 5'h0c, 1'b0, 1'b0, 0, 3, 0};
        tbl[3]  = '{1'b0, 5'h00, 1'b0, 1'b0, 0, 3, 0};
        tbl[4]  = '{1'b1, 5'h10, 1'b0, 1'b0, 0, 3, 0};
        tbl[5]  = '{1'b1, 5'h10, 1'b0, 1'b0, 1, 3, 0};
        tbl[6]  = '{1'b1, 5'h10, 1'b0, 1'b0, 1, 3, 0};
        tbl[7]  = '{1'b0, 5'h10, 1'b1, 1'b0, 1, 3, 0};
        tbl[8]  = '{1'b0, 5'h10, 1'b0, 1'b0, 1, 3, 1};
        tbl[9]  = '{1'b0, 5'h10, 1'b1, 1'b0, 1, 3, 1};
        tbl[10] = '{1'b0, 5'h10, 1'b1, 1'b0, 1, 3, 2};
        tbl[11] = '{1'b0, 5'h10, 1'b1, 1'b0, 1, 3, 2};
        tbl[12] = '{1'b0, 5'h10, 1'b0, 1'b1, 1, 3, 2};
        tbl[13] = '{1'b0, 5'h10, 1'b0, 1'b0, 2, 2, 2};
        tbl[14] = '{1'b0, 5'h10, 1'b1, 1'b0, 2, 2, 2};
        tbl[15] = '{1'b0, 5'h10, 1'b0, 1'b0, 2, 2, 2};
        tbl[16] = '{1'b0, 5'h10, 1'b0, 1'b0, 2, 2, 2};
        tbl[17] = '{1'b0, 5'h10, 1'b0, 1'b0, 1, 2, 2};

        // Reset held for two edges
        rstn = 1'b0;
        tick(); tick();
        check_all("reset", 0, BI, 0);
        rstn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            key_ready = tbl[i].kr; key_code = tbl[i].kc; hit = tbl[i].h; miss = tbl[i].m;
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].b, tbl[i].s);
        end

        // Score counting, a held hit and saturation
        do_reset();
        start_game();
        check_all("start", 1, 3, 0);
        for (int i = 0; i < 10; i++) pulse_hit();
        check_all("hit10", 1, 3, 10);
        hit = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        hit = 1'b0; tick(); tick();
        check_all("hold", 1, 3, 11);
        for (int i = 0; i < 9987; i++) pulse_hit();
        check_all("s9998", 1, 3, 9998);
        for (int i = 0; i < 3; i++) pulse_hit();
        check_all("sat", 1, 3, 9999);

        // Ball loss down to game over. A key press during OVER is ignored.
        pulse_miss();
        check_all("miss1", 2, 2, 9999);
        tick(); tick(); tick();
        check_all("nb_wait", 2, 2, 9999);
        tick();
        check_all("nb_serve", 1, 2, 9999);
        pulse_miss();
        tick(); tick(); tick(); tick();
        check_all("miss2", 1, 1, 9999);
        pulse_miss();
        check_all("over", 3, 0, 9999);
        key_code = 5'h10; key_ready = 1'b1; tick();
        key_ready = 1'b0;
        tick(); tick(); tick(); tick();
        check_all("over_wait", 3, 0, 9999);
        tick();
        check_all("over_end", 0, 3, 9999);
        tick();
        check_all("over_key_ign", 0, 3, 9999);
        start_game();
        check_all("restart", 1, 3, 0);

        // Simultaneous hit and miss, then a reset during NEWBALL
        pulse_miss();
        tick(); tick(); tick(); tick();
        hit = 1'b1; miss = 1'b1; tick();
        hit = 1'b0; miss = 1'b0; tick();
        check_all("hit_miss", 2, 1, 1);
        tick();
        rstn = 1'b0; tick();
        check_all("rst_nb", 0, 3, 0);
        rstn = 1'b1;

        // Randomized run against the reference model
        do_reset();
        model_reset();
        m_cyc = 0;
        for (int i = 0; i < 4000; i++) begin
            rstn      = ($urandom_range(0, 199) != 0);
            key_ready = ($urandom_range(0, 2) == 0);
            key_code  = ($urandom_range(0, 1) != 0) ? 5'h10 : 5'($urandom);
            hit       = ($urandom_range(0, 2) == 0);
            miss      = ($urandom_range(0, 11) == 0);
            tick();
            model_edge(rstn, key_ready, key_code, hit, miss);
            check_all("rand", m_st, m_b, m_s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
